// File: rtl/psd_pkg.sv
// Shared definitions for the audio sample path: sample width, phase width,
// the signed sample type and the interpolator mode encodings.
package psd_pkg;

  localparam int DW = 18;
  localparam int KW = 3;

  typedef logic signed [DW-1:0] sample_t;

  localparam logic MODE_ZOH = 1'b0;
  localparam logic MODE_LIN = 1'b1;

endpackage

// File: rtl/interp_mac.sv
// Combinational interpolation datapath: y = prev + floor((cur - prev) * k / 2^nlog2)
// in linear mode, or y = cur in zero-order-hold mode.
module interp_mac #(
  parameter int DW = psd_pkg::DW,
  parameter int KW = psd_pkg::KW
) (
  input  logic [DW-1:0] prev,
  input  logic [DW-1:0] cur,
  input  logic [KW-1:0] k,
  input  logic [1:0]    nlog2,
  input  logic          mode,
  output logic [DW-1:0] y
);
  import psd_pkg::*;

  localparam int PW = DW + KW + 1;

  logic signed [PW-1:0] diff_x;
  logic signed [PW-1:0] k_x;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;
  logic signed [PW-1:0] sum;

  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
    diff_x  = PW'($signed(cur)) - PW'($signed(prev));
    k_x     = $signed({{(DW + 1){1'b0}}, k});
    prod    = diff_x * k_x;
    // Arithmetic shift gives floor rounding; the result always lies between prev and cur.
    shifted = prod >>> nlog2;
    sum     = PW'($signed(prev)) + shifted;
    y       = (mode == MODE_LIN) ? DW'(sum) : cur;
  end

endmodule

// File: rtl/upsample_interp.sv
// Rate-restoring interpolator: loads one low-rate sample per endatain strobe and
// emits one zero-order-hold or linearly interpolated sample per enbase tick.
module upsample_interp #(
  parameter int DW = psd_pkg::DW,
  parameter int KW = psd_pkg::KW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    Nlog2,
  input  logic          mode,
  input  logic [DW-1:0] datain,
  input  logic          endatain,
  input  logic          enbase,
  output logic [DW-1:0] dataout,
  output logic          endataout,
  output logic          underrun
);

  logic [DW-1:0] prev_q, prev_d;
  logic [DW-1:0] cur_q, cur_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] dataout_q, dataout_d;
  logic          endataout_q, endataout_d;
  logic          underrun_q, underrun_d;

  logic [KW-1:0] k_max;
  logic [KW-1:0] k_eff;
  logic [DW-1:0] y;

  // A phase left above N-1 by an Nlog2 change is treated as N-1.
  always_comb begin
    k_max = KW'((1 << Nlog2) - 1);
    k_eff = (k_q > k_max) ? k_max : k_q;
  end

  interp_mac #(
    .DW(DW),
    .KW(KW)
  ) u_mac (
    .prev  (prev_q),
    .cur   (cur_q),
    .k     (k_eff),
    .nlog2 (Nlog2),
    .mode  (mode),
    .y     (y)
  );

  always_comb begin
    prev_d      = prev_q;
    cur_d       = cur_q;
    k_d         = k_q;
    dataout_d   = dataout_q;
    endataout_d = 1'b0;
    underrun_d  = 1'b0;

    if (enbase) begin
      dataout_d   = y;
      endataout_d = 1'b1;
      if (k_eff < k_max) begin
        k_d = k_eff + KW'(1);
      end else begin
        k_d        = k_eff;
        underrun_d = ~endatain;
      end
    end

    // The load comes after the output computation so its k reset wins.
    if (endatain) begin
      prev_d = cur_q;
      cur_d  = datain;
      k_d    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q      <= '0;
      cur_q       <= '0;
      k_q         <= '0;
      dataout_q   <= '0;
      endataout_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      k_q         <= k_d;
      dataout_q   <= dataout_d;
      endataout_q <= endataout_d;
      underrun_q  <= underrun_d;
    end
  end

  assign dataout   = dataout_q;
  assign endataout = endataout_q;
  assign underrun  = underrun_q;

endmodule
